// File: rtl/regfile_display_ctrl_if.sv
// Board-side bundle between the register-file display controller and the board:
// raw buttons, the register-file display read port and the 7-segment drive.
interface regfile_display_ctrl_if;
  logic        btn_next;
  logic        btn_prev;
  logic        btn_half;
  logic [31:0] display_data;
  logic [4:0]  display_reg;
  logic [3:0]  anode;
  logic [6:0]  cathode;
  logic        dp;

  modport master (
    input  btn_next, btn_prev, btn_half, display_data,
    output display_reg, anode, cathode, dp
  );

  modport slave (
    output btn_next, btn_prev, btn_half, display_data,
    input  display_reg, anode, cathode, dp
  );
endinterface

// File: rtl/regfile_display_ctrl.sv
// Debounced register/half selector plus 4-digit active-low hex scan of the register file display port.
// Buttons act DEBOUNCE_CYCLES+3 edges after press; segment outputs lag by one edge. RFDISP_HALF_DP_EN lights dp on digit 0 for the upper half.
module regfile_display_ctrl #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CLK_DIV         = 100000
) (
  input  logic                   clk,
  input  logic                   reset,
  regfile_display_ctrl_if.master bus
);
  localparam int DBW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int DVW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

  // Bit order for all button vectors: {half, prev, next}
  logic [2:0]     raw;
  logic [2:0]     sync1;
  logic [2:0]     sync2;
  logic [2:0]     db;
  logic [2:0]     db_q;
  logic [2:0]     pulse;
  logic [DBW-1:0] cnt [3];

  logic [4:0]     sel_reg;
  logic           half;
  logic [DVW-1:0] div;
  logic [1:0]     digit;
  logic [3:0]     nibble;
  logic [6:0]     seg;
  logic [3:0]     anode_r;
  logic [6:0]     cathode_r;

  assign raw = {bus.btn_half, bus.btn_prev, bus.btn_next};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
      db    <= '0;
      db_q  <= '0;
      for (int i = 0; i < 3; i++) cnt[i] <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      db_q  <= db;
      for (int i = 0; i < 3; i++) begin
        if (sync2[i] == db[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == DBW'(DEBOUNCE_CYCLES - 1)) begin
          cnt[i] <= '0;
          db[i]  <= sync2[i];
        end else begin
          cnt[i] <= cnt[i] + DBW'(1);
        end
      end
    end
  end

  // Rising edge of the debounced level only; releases are silent.
  assign pulse = db & ~db_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sel_reg <= '0;
      half    <= 1'b0;
    end else begin
      if (pulse[0] && !pulse[1])
        sel_reg <= sel_reg + 5'd1;
      else if (pulse[1] && !pulse[0])
        sel_reg <= sel_reg - 5'd1;
      if (pulse[2])
        half <= ~half;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div   <= '0;
      digit <= '0;
    end else if (div == DVW'(CLK_DIV - 1)) begin
      div   <= '0;
      digit <= digit + 2'd1;
    end else begin
      div <= div + DVW'(1);
    end
  end

  // Bit offset is 16*half + 4*digit.
  assign nibble = bus.display_data[{half, digit, 2'b00} +: 4];

  always_comb begin
    seg = 7'h7F;
    case (nibble)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      4'hF: seg = 7'h0E;
      default: seg = 7'h7F;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      anode_r   <= 4'b1110;
      cathode_r <= 7'h7F;
    end else begin
      anode_r   <= ~(4'b0001 << digit);
      cathode_r <= seg;
    end
  end

`ifdef RFDISP_HALF_DP_EN
  logic dp_r;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      dp_r <= 1'b1;
    else
      dp_r <= ~((digit == 2'd0) && half);
  end

  assign bus.dp = dp_r;
`else
  assign bus.dp = 1'b1;
`endif

  assign bus.display_reg = sel_reg;
  assign bus.anode       = anode_r;
  assign bus.cathode     = cathode_r;
endmodule

// File: tb/tb_regfile_display_ctrl.sv
// Scoreboard bench for regfile_display_ctrl: stimulus queues expectations, a negedge monitor pops and compares.
module tb_regfile_display_ctrl;
  localparam int DEB = 4;
  localparam int DIV = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  int          cycle = 0;
  int          checks = 0;
  int          errors = 0;
  logic [31:0] regs [32];

  regfile_display_ctrl_if bus();
  assign bus.display_data = regs[bus.display_reg];

  regfile_display_ctrl #(.DEBOUNCE_CYCLES(DEB), .CLK_DIV(DIV)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  typedef struct { logic [4:0] val; int cyc; } reg_exp_t;
  typedef struct { logic [3:0] an; logic [6:0] cat; logic dp; } scan_exp_t;
  typedef struct { int cyc; bit full; logic [3:0] an; logic [6:0] cat; logic dp; } timed_exp_t;

  reg_exp_t   reg_q[$];
  scan_exp_t  scan_q[$];
  timed_exp_t timed_q[$];
  bit         scan_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  function automatic logic exp_dp(input logic [3:0] an, input logic hf);
`ifdef RFDISP_HALF_DP_EN
    return !(hf && an == 4'b1110);
`else
    return 1'b1;
`endif
  endfunction

  // Monitor
  logic [4:0]  last_reg = 5'd0;
  logic [11:0] last_out = '0;
  logic [11:0] cur_out;
  int          hold = 0;
  bit          full_run = 1'b0;
  reg_exp_t    re;
  scan_exp_t   se;
  timed_exp_t  te;

  always @(negedge clk) begin
    if (bus.display_reg !== last_reg) begin
      if (reg_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL reg_unexpected: got %0d, no change required from %0d (cycle %0d)",
                 bus.display_reg, last_reg, cycle);
      end else begin
        re = reg_q.pop_front();
        check("display_reg", bus.display_reg, re.val);
        check("reg_edge", cycle, re.cyc);
      end
      last_reg = bus.display_reg;
    end

    cur_out = {bus.anode, bus.cathode, bus.dp};
    if (scan_en) begin
      if (cur_out !== last_out) begin
        if (full_run) check("digit_hold", hold, DIV);
        if (scan_q.size() > 0) begin
          se = scan_q.pop_front();
          check("scan_anode", bus.anode, se.an);
          check("scan_cathode", bus.cathode, se.cat);
          check("scan_dp", bus.dp, se.dp);
        end
        full_run = 1'b1;
        hold = 1;
      end else begin
        hold++;
      end
    end else begin
      full_run = 1'b0;
      hold = 0;
    end
    last_out = cur_out;

    while (timed_q.size() > 0 && timed_q[0].cyc <= cycle) begin
      te = timed_q.pop_front();
      check("timed_edge", cycle, te.cyc);
      check("timed_cathode", bus.cathode, te.cat);
      if (te.full) begin
        check("timed_anode", bus.anode, te.an);
        check("timed_dp", bus.dp, te.dp);
      end
    end
  end

  // Stimulus
  task automatic press(input bit n, input bit p, input bit h, input int held, input int exp_val);
    if (exp_val >= 0) reg_q.push_back('{val: 5'(exp_val), cyc: cycle + DEB + 3});
    bus.btn_next = n;
    bus.btn_prev = p;
    bus.btn_half = h;
    repeat (held) @(negedge clk);
    bus.btn_next = 1'b0;
    bus.btn_prev = 1'b0;
    bus.btn_half = 1'b0;
    repeat (12) @(negedge clk);
  endtask

  task automatic wait_anode(input logic [3:0] an);
    int n = 0;
    while (bus.anode !== an && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (bus.anode !== an) begin
      checks++;
      errors++;
      $display("FAIL wait_anode: got %b required %b", bus.anode, an);
    end
  endtask

  task automatic run_scan(input logic [6:0] c0, input logic [6:0] c1, input logic [6:0] c2,
                          input logic [6:0] c3, input logic hf);
    int n = 0;
    wait_anode(4'b0111);
    #1;
    for (int r = 0; r < 2; r++) begin
      scan_q.push_back('{an: 4'b1110, cat: c0, dp: exp_dp(4'b1110, hf)});
      scan_q.push_back('{an: 4'b1101, cat: c1, dp: exp_dp(4'b1101, hf)});
      scan_q.push_back('{an: 4'b1011, cat: c2, dp: exp_dp(4'b1011, hf)});
      scan_q.push_back('{an: 4'b0111, cat: c3, dp: exp_dp(4'b0111, hf)});
    end
    scan_en = 1'b1;
    while (scan_q.size() > 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (scan_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL scan_timeout: got %0d pending required 0", scan_q.size());
      scan_q.delete();
    end
    scan_en = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_display_reg"}, bus.display_reg, 5'd0);
    check({tag, "_anode"}, bus.anode, 4'b1110);
    check({tag, "_cathode"}, bus.cathode, 7'h7F);
    check({tag, "_dp"}, bus.dp, 1'b1);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) regs[i] = 32'h0101_0101 * i;
    regs[0]  = 32'h1234_ABCD;
    regs[31] = 32'hDEAD_BEEF;
    bus.btn_next = 1'b0;
    bus.btn_prev = 1'b0;
    bus.btn_half = 1'b0;

    // Power-on reset, then first edge shows digit 0 of register 0 (D -> 21)
    #1 reset = 1'b1;
    #2 check_reset_outputs("por");
    repeat (2) @(negedge clk);
    reset = 1'b0;
    timed_q.push_back('{cyc: cycle + 1, full: 1'b1, an: 4'b1110, cat: 7'h21, dp: 1'b1});
    repeat (6) @(negedge clk);

    // Reset in the middle of a scan and a debounce
    bus.btn_next = 1'b1;
    repeat (3) @(negedge clk);
    @(posedge clk);
    #2 reset = 1'b1;
    #1 check_reset_outputs("mid");
    @(negedge clk);
    bus.btn_next = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    timed_q.push_back('{cyc: cycle + 1, full: 1'b1, an: 4'b1110, cat: 7'h21, dp: 1'b1});
    repeat (12) @(negedge clk);

    // Debounce: long hold steps once at edge 7, short glitch is ignored
    press(1'b1, 1'b0, 1'b0, 12, 1);
    press(1'b1, 1'b0, 1'b0, 2, -1);

    // Wrap and simultaneous presses
    press(1'b0, 1'b1, 1'b0, 8, 0);
    press(1'b0, 1'b1, 1'b0, 8, 31);
    press(1'b1, 1'b0, 1'b0, 8, 0);
    press(1'b1, 1'b1, 1'b0, 8, -1);

    // Scan of 1234ABCD, lower half: D C B A
    run_scan(7'h21, 7'h46, 7'h03, 7'h08, 1'b0);

    // Upper half: 4 3 2 1
    press(1'b0, 1'b0, 1'b1, 8, -1);
    run_scan(7'h19, 7'h30, 7'h24, 7'h79, 1'b1);

    // Live writes on the falling edge appear at the next rising edge
    @(negedge clk);
    regs[0] = 32'hFFFF_0000;
    timed_q.push_back('{cyc: cycle + 1, full: 1'b0, an: 4'b0000, cat: 7'h0E, dp: 1'b1});
    repeat (3) @(negedge clk);
    press(1'b0, 1'b0, 1'b1, 8, -1);
    regs[0] = 32'h0000_FFFF;
    timed_q.push_back('{cyc: cycle + 1, full: 1'b0, an: 4'b0000, cat: 7'h0E, dp: 1'b1});
    repeat (2) @(negedge clk);
    regs[0] = 32'hFFFF_0000;
    timed_q.push_back('{cyc: cycle + 1, full: 1'b0, an: 4'b0000, cat: 7'h40, dp: 1'b1});
    repeat (4) @(negedge clk);

    check("reg_q_drained", reg_q.size(), 0);
    check("timed_q_drained", timed_q.size(), 0);
    check("final_reg", bus.display_reg, 5'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
